// File: rtl/video_mode_ctrl.sv
// Video mode sequencer: holds the four timing presets and walks the HDMI timing
// generator through reset, pixel-PLL switch, lock wait and first-vsync confirmation.
module video_mode_ctrl #(
  parameter int X_BITS         = 12,
  parameter int Y_BITS         = 12,
  parameter int RST_CYCLES     = 16,
  parameter int PLL_STABLE     = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [1:0]        req_mode,
  output logic              req_ready,
  input  logic              tg_vs,
  input  logic              pll_locked,
  output logic [1:0]        pclk_sel,
  output logic              tg_reset,
  output logic              interlaced,
  output logic [Y_BITS-1:0] v_total_0,
  output logic [Y_BITS-1:0] v_fp_0,
  output logic [Y_BITS-1:0] v_bp_0,
  output logic [Y_BITS-1:0] v_sync_0,
  output logic [Y_BITS-1:0] v_total_1,
  output logic [Y_BITS-1:0] v_fp_1,
  output logic [Y_BITS-1:0] v_bp_1,
  output logic [Y_BITS-1:0] v_sync_1,
  output logic [X_BITS-1:0] h_total,
  output logic [X_BITS-1:0] h_fp,
  output logic [X_BITS-1:0] h_bp,
  output logic [X_BITS-1:0] h_sync,
  output logic [X_BITS-1:0] hv_offset_0,
  output logic [X_BITS-1:0] hv_offset_1,
  output logic [1:0]        cur_mode,
  output logic              busy,
  output logic              mode_locked,
  output logic              mode_err,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, WAIT_FRAME, HOLD, WAIT_PLL, WAIT_VS} state_t;

  typedef struct packed {
    logic              interlaced;
    logic [X_BITS-1:0] h_total, h_fp, h_bp, h_sync, hv_offset_0, hv_offset_1;
    logic [Y_BITS-1:0] v_total_0, v_fp_0, v_bp_0, v_sync_0;
    logic [Y_BITS-1:0] v_total_1, v_fp_1, v_bp_1, v_sync_1;
  } cfg_t;

  localparam logic [23:0] RST_LAST = 24'(RST_CYCLES - 1);
  localparam logic [23:0] PLL_LAST = 24'(PLL_STABLE - 1);
  localparam logic [23:0] TO_LAST  = 24'(TIMEOUT_CYCLES - 1);

  function automatic cfg_t pack_cfg(input int ht, hf, hb, hs, vt0, vf0, vb0, vs0,
                                    input int vt1, vf1, vb1, vs1, o0, o1, input logic il);
    cfg_t c;
    c.interlaced  = il;
    c.h_total     = X_BITS'(ht);  c.h_fp      = X_BITS'(hf);
    c.h_bp        = X_BITS'(hb);  c.h_sync    = X_BITS'(hs);
    c.hv_offset_0 = X_BITS'(o0);  c.hv_offset_1 = X_BITS'(o1);
    c.v_total_0   = Y_BITS'(vt0); c.v_fp_0    = Y_BITS'(vf0);
    c.v_bp_0      = Y_BITS'(vb0); c.v_sync_0  = Y_BITS'(vs0);
    c.v_total_1   = Y_BITS'(vt1); c.v_fp_1    = Y_BITS'(vf1);
    c.v_bp_1      = Y_BITS'(vb1); c.v_sync_1  = Y_BITS'(vs1);
    return c;
  endfunction

  function automatic cfg_t mode_cfg(input logic [1:0] m);
    unique case (m)
      2'd0:    return pack_cfg(800,  16,  48,  96, 525,  10, 33, 2, 525,  10, 33, 2, 0, 0,    1'b0);
      2'd1:    return pack_cfg(1650, 110, 220, 40, 750,  5,  20, 5, 750,  5,  20, 5, 0, 0,    1'b0);
      2'd2:    return pack_cfg(2200, 88,  148, 44, 1125, 4,  36, 5, 1125, 4,  36, 5, 0, 0,    1'b0);
      default: return pack_cfg(2200, 88,  148, 44, 562,  2,  15, 5, 563,  2,  16, 5, 0, 1100, 1'b1);
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [1:0]  target_q, target_d, cur_mode_q, cur_mode_d, pclk_sel_q, pclk_sel_d;
  cfg_t        cfg_q, cfg_d;
  logic        tg_reset_q, tg_reset_d, busy_q, busy_d, req_ready_q, req_ready_d;
  logic        mode_locked_q, mode_locked_d, mode_err_q, mode_err_d, done_q, done_d;
  logic        vs_s1_q, vs_s2_q, vs_prev_q, pll_s1_q, pll_s2_q;
  logic        vs_rise, load;
  logic [1:0]  load_mode;

  assign vs_rise = vs_s2_q & ~vs_prev_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d       = state_q;
    cnt_d         = (cnt_q == '1) ? cnt_q : cnt_q + 24'd1;
    target_d      = target_q;
    mode_err_d    = mode_err_q;
    mode_locked_d = mode_locked_q;
    tg_reset_d    = tg_reset_q;
    done_d        = 1'b0;
    load          = 1'b0;
    load_mode     = target_q;

    unique case (state_q)
      IDLE: if (req_valid && req_ready_q) begin
        target_d   = req_mode;
        mode_err_d = 1'b0;
        if (req_mode == cur_mode_q && mode_locked_q) begin
          done_d = 1'b1;
        end else if (mode_locked_q) begin
          state_d = WAIT_FRAME;
        end else begin
          state_d   = HOLD;
          load      = 1'b1;
          load_mode = req_mode;
        end
      end
      WAIT_FRAME: if (vs_rise || cnt_q >= TO_LAST) begin
        state_d = HOLD;
        load    = 1'b1;
      end
      HOLD: if (cnt_q >= RST_LAST) state_d = WAIT_PLL;
      WAIT_PLL: begin
        if (!pll_s2_q) begin
          cnt_d = '0;
        end else if (cnt_q >= PLL_LAST) begin
          state_d    = WAIT_VS;
          tg_reset_d = 1'b0;
        end
      end
      WAIT_VS: begin
        if (vs_rise) begin
          mode_locked_d = 1'b1;
          done_d        = 1'b1;
          state_d       = IDLE;
        end else if (cnt_q >= TO_LAST) begin
          mode_err_d    = 1'b1;
          mode_locked_d = 1'b0;
          done_d        = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Config, PLL select and generator reset change together on the HOLD entry edge.
    cfg_d      = cfg_q;
    pclk_sel_d = pclk_sel_q;
    cur_mode_d = cur_mode_q;
    if (load) begin
      cfg_d         = mode_cfg(load_mode);
      pclk_sel_d    = load_mode;
      cur_mode_d    = load_mode;
      tg_reset_d    = 1'b1;
      mode_locked_d = 1'b0;
    end

    if (state_d != state_q) cnt_d = '0;
    busy_d      = (state_d != IDLE);
    req_ready_d = (state_d == IDLE);
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HOLD;
      cnt_q         <= '0;
      target_q      <= 2'd0;
      cfg_q         <= mode_cfg(2'd0);
      pclk_sel_q    <= 2'd0;
      cur_mode_q    <= 2'd0;
      tg_reset_q    <= 1'b1;
      busy_q        <= 1'b1;
      req_ready_q   <= 1'b0;
      mode_locked_q <= 1'b0;
      mode_err_q    <= 1'b0;
      done_q        <= 1'b0;
      vs_s1_q       <= 1'b0;
      vs_s2_q       <= 1'b0;
      vs_prev_q     <= 1'b0;
      pll_s1_q      <= 1'b0;
      pll_s2_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      target_q      <= target_d;
      cfg_q         <= cfg_d;
      pclk_sel_q    <= pclk_sel_d;
      cur_mode_q    <= cur_mode_d;
      tg_reset_q    <= tg_reset_d;
      busy_q        <= busy_d;
      req_ready_q   <= req_ready_d;
      mode_locked_q <= mode_locked_d;
      mode_err_q    <= mode_err_d;
      done_q        <= done_d;
      vs_s1_q       <= tg_vs;
      vs_s2_q       <= vs_s1_q;
      vs_prev_q     <= vs_s2_q;
      pll_s1_q      <= pll_locked;
      pll_s2_q      <= pll_s1_q;
    end
  end

  assign req_ready   = req_ready_q;
  assign pclk_sel    = pclk_sel_q;
  assign tg_reset    = tg_reset_q;
  assign cur_mode    = cur_mode_q;
  assign busy        = busy_q;
  assign mode_locked = mode_locked_q;
  assign mode_err    = mode_err_q;
  assign done        = done_q;
  assign interlaced  = cfg_q.interlaced;
  assign h_total     = cfg_q.h_total;
  assign h_fp        = cfg_q.h_fp;
  assign h_bp        = cfg_q.h_bp;
  assign h_sync      = cfg_q.h_sync;
  assign hv_offset_0 = cfg_q.hv_offset_0;
  assign hv_offset_1 = cfg_q.hv_offset_1;
  assign v_total_0   = cfg_q.v_total_0;
  assign v_fp_0      = cfg_q.v_fp_0;
  assign v_bp_0      = cfg_q.v_bp_0;
  assign v_sync_0    = cfg_q.v_sync_0;
  assign v_total_1   = cfg_q.v_total_1;
  assign v_fp_1      = cfg_q.v_fp_1;
  assign v_bp_1      = cfg_q.v_bp_1;
  assign v_sync_1    = cfg_q.v_sync_1;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Randomised bench for video_mode_ctrl: a free-running vsync source plus a
// transaction-level model of which mode should end up loaded, locked or in error.
module tb_video_mode_ctrl;

  localparam int XB = 12, YB = 12, RSTC = 16, PLLS = 16, TMO = 100;
  localparam int VS_PERIOD = 40;
  localparam int BUDGET = 1000;

  logic clk, reset, req_valid, req_ready, tg_vs, pll_locked, tg_reset, interlaced;
  logic [1:0] req_mode, pclk_sel, cur_mode;
  logic [YB-1:0] v_total_0, v_fp_0, v_bp_0, v_sync_0, v_total_1, v_fp_1, v_bp_1, v_sync_1;
  logic [XB-1:0] h_total, h_fp, h_bp, h_sync, hv_offset_0, hv_offset_1;
  logic busy, mode_locked, mode_err, done;

  video_mode_ctrl #(.X_BITS(XB), .Y_BITS(YB), .RST_CYCLES(RSTC), .PLL_STABLE(PLLS),
                    .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_mode(req_mode), .req_ready(req_ready),
    .tg_vs(tg_vs), .pll_locked(pll_locked), .pclk_sel(pclk_sel), .tg_reset(tg_reset),
    .interlaced(interlaced), .v_total_0(v_total_0), .v_fp_0(v_fp_0), .v_bp_0(v_bp_0),
    .v_sync_0(v_sync_0), .v_total_1(v_total_1), .v_fp_1(v_fp_1), .v_bp_1(v_bp_1),
    .v_sync_1(v_sync_1), .h_total(h_total), .h_fp(h_fp), .h_bp(h_bp), .h_sync(h_sync),
    .hv_offset_0(hv_offset_0), .hv_offset_1(hv_offset_1), .cur_mode(cur_mode), .busy(busy),
    .mode_locked(mode_locked), .mode_err(mode_err), .done(done));

  // Preset table as published for the four modes.
  int t_ht[4]  = '{800, 1650, 2200, 2200};
  int t_hf[4]  = '{16, 110, 88, 88};
  int t_hb[4]  = '{48, 220, 148, 148};
  int t_hs[4]  = '{96, 40, 44, 44};
  int t_vt0[4] = '{525, 750, 1125, 562};
  int t_vt1[4] = '{525, 750, 1125, 563};
  int t_vf0[4] = '{10, 5, 4, 2};
  int t_vb0[4] = '{33, 20, 36, 15};
  int t_vb1[4] = '{33, 20, 36, 16};
  int t_vs[4]  = '{2, 5, 5, 5};
  int t_o1[4]  = '{0, 0, 0, 1100};
  int t_il[4]  = '{0, 0, 0, 1};

  int n_checks = 0, n_errors = 0;
  int model_mode = 0;
  bit model_locked = 0, model_err = 0;
  bit vs_en = 1;
  int fc;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Pixel-side generator stand-in: frame counter held while the generator is in reset.
  initial begin
    tg_vs = 0;
    fc = 0;
    forever begin
      @(posedge clk); #2;
      if (tg_reset || !vs_en) begin
        fc = 0;
        tg_vs = 0;
      end else begin
        fc = (fc + 1) % VS_PERIOD;
        tg_vs = (fc >= VS_PERIOD - 4);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_cfg(input int m);
    check("h_total", h_total, t_ht[m]);         check("h_fp", h_fp, t_hf[m]);
    check("h_bp", h_bp, t_hb[m]);               check("h_sync", h_sync, t_hs[m]);
    check("v_total_0", v_total_0, t_vt0[m]);    check("v_total_1", v_total_1, t_vt1[m]);
    check("v_fp_0", v_fp_0, t_vf0[m]);          check("v_fp_1", v_fp_1, t_vf0[m]);
    check("v_bp_0", v_bp_0, t_vb0[m]);          check("v_bp_1", v_bp_1, t_vb1[m]);
    check("v_sync_0", v_sync_0, t_vs[m]);       check("v_sync_1", v_sync_1, t_vs[m]);
    check("hv_offset_0", hv_offset_0, 0);       check("hv_offset_1", hv_offset_1, t_o1[m]);
    check("interlaced", interlaced, t_il[m]);   check("pclk_sel", pclk_sel, m);
    check("cur_mode", cur_mode, m);
  endtask

  // Called on the first sample after reset is released.
  task automatic boot_check();
    int n, idx;
    n = 0;
    while (tg_reset && n < 200) begin n++; step(); end
    check("boot_rst_len_ok", (n >= RSTC + PLLS && n <= RSTC + PLLS + 2), 1);
    idx = 0;
    while (!done && idx < 200) begin step(); idx++; end
    check("boot_done", done, 1);
    check("boot_locked", mode_locked, 1);
    check("boot_err", mode_err, 0);
    check("boot_busy", busy, 0);
    check("boot_ready", req_ready, 1);
    check_cfg(0);
    step();
    check("boot_done_len", done, 0);
    model_mode = 0;
    model_locked = 1;
    model_err = 0;
  endtask

  task automatic request(input int mode, input bit vs_on, input bit glitch);
    bit same, busy_seen, vs_seen, vs_before_rst, prev_vs;
    int idx, done_idx, rise_idx, fall_idx, rst_hi, pll_hi_idx;
    same = model_locked && (mode == model_mode);
    vs_en = vs_on;
    idx = 0;
    while (!req_ready && idx < 200) begin step(); idx++; end
    check("req_ready", req_ready, 1);
    req_valid = 1;
    req_mode = 2'(mode);
    step();
    req_valid = 0;
    check("err_clear", mode_err, 0);

    idx = 0; done_idx = -1; rise_idx = -1; fall_idx = -1; rst_hi = 0; pll_hi_idx = -1;
    busy_seen = 0; vs_seen = 0; vs_before_rst = 0; prev_vs = tg_vs;
    while (done_idx < 0 && idx < BUDGET) begin
      if (tg_vs && !prev_vs) vs_seen = 1;
      prev_vs = tg_vs;
      if (busy) busy_seen = 1;
      if (tg_reset) begin
        if (rise_idx < 0) begin rise_idx = idx; vs_before_rst = vs_seen; end
        rst_hi++;
      end else if (rise_idx >= 0 && fall_idx < 0) begin
        fall_idx = idx;
      end
      if (done) done_idx = idx;
      if (glitch && tg_reset && rst_hi < 40) begin
        pll_locked = (rst_hi % 10 != 9);
      end else begin
        if (glitch && tg_reset && rst_hi == 40) pll_hi_idx = idx;
        pll_locked = 1;
      end
      // Competing requests while busy must be ignored.
      req_valid = busy && ($urandom_range(0, 1) == 1);
      req_mode = 2'($urandom_range(0, 3));
      if (done_idx < 0) begin step(); idx++; end
    end
    req_valid = 0;
    pll_locked = 1;
    check("done_seen", (done_idx >= 0), 1);

    if (same) begin
      check("same_no_rst", (rise_idx < 0), 1);
      check("same_no_busy", busy_seen, 0);
      check("same_done_lat", done_idx, 0);
    end else begin
      if (!model_locked)  check("direct_hold", rise_idx, 0);
      else if (vs_on)     check("rst_after_vs", vs_before_rst, 1);
      else                check("frame_timeout", rise_idx, TMO);
      if (glitch) check("pll_stable", fall_idx - pll_hi_idx, PLLS + 2);
      else        check("rst_len", fall_idx - rise_idx, RSTC + PLLS);
      if (!vs_on) check("vs_timeout", done_idx - fall_idx, TMO);
      model_mode = mode;
      model_locked = vs_on;
      model_err = !vs_on;
    end
    if (same) model_err = 0;

    check("mode_locked", mode_locked, model_locked);
    check("mode_err", mode_err, model_err);
    check("tg_reset_end", tg_reset, 0);
    check_cfg(model_mode);
    step();
    check("done_len", done, 0);
  endtask

  initial begin
    reset = 1; req_valid = 0; req_mode = 0; pll_locked = 1;
    repeat (3) step();
    check("rst_tg_reset", tg_reset, 1);
    check("rst_busy", busy, 1);
    check("rst_ready", req_ready, 0);
    check("rst_locked", mode_locked, 0);
    check("rst_err", mode_err, 0);
    check("rst_done", done, 0);
    check_cfg(0);
    reset = 0;
    boot_check();

    request(3, 1, 0);   // progressive -> interlaced through a frame wait
    request(3, 1, 0);   // same mode while locked
    request(1, 1, 1);   // PLL lock glitching during the wait
    request(2, 0, 0);   // no vsync: frame wait and confirm both time out
    request(2, 1, 0);   // recovery from error goes straight to HOLD
    repeat (12) request($urandom_range(0, 3), ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) == 0));

    request(0, 1, 0);
    vs_en = 1;
    req_valid = 1;
    req_mode = 2'd2;
    step();
    req_valid = 0;
    check("wf_busy", busy, 1);
    check("wf_running", tg_reset, 0);
    reset = 1;
    step();
    check("mid_rst_tg_reset", tg_reset, 1);
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_locked", mode_locked, 0);
    check_cfg(0);
    step();
    reset = 0;
    boot_check();
    request(2, 1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/video_mode_ctrl.md
Name: video_mode_ctrl

Overview:
Mode sequencer for the HDMI sync/timing generator. Holds a fixed table of four video timing presets and drives the generator's full configuration bus. Also drives its reset and the pixel-PLL select. Mode changes are accepted over a valid/ready handshake and sequenced as: wait for frame end, hold the generator in reset, switch the PLL, wait for PLL lock, release, confirm the first vsync.

Parameters:
X_BITS, 12, horizontal config width
Y_BITS, 12, vertical config width
RST_CYCLES, 16, cycles the generator is held in reset after the table load
PLL_STABLE, 16, consecutive synced pll_locked=1 cycles required
TIMEOUT_CYCLES, 2000000, frame-wait and vsync-confirm timeout (24-bit counter)

Ports:
clk  in  1  control clock, free-running, independent of the pixel clock
reset  in  1  synchronous, active-high
req_valid  in  1  mode change request
req_mode  in  2  requested mode id
req_ready  out  1  request accepted when req_valid && req_ready
tg_vs  in  1  generator vs_out, pixel domain; 2-FF synchronised internally
pll_locked  in  1  pixel PLL lock, async; 2-FF synchronised internally
pclk_sel  out  2  pixel PLL preset select
tg_reset  out  1  generator reset
interlaced, v_total_0/1, v_fp_0/1, v_bp_0/1, v_sync_0/1  out  1/Y_BITS  generator vertical config
h_total, h_fp, h_bp, h_sync, hv_offset_0/1  out  X_BITS  generator horizontal config
cur_mode  out  2  mode currently loaded
busy  out  1  sequence in progress
mode_locked  out  1  current mode confirmed running
mode_err  out  1  last sequence timed out on vsync confirm
done  out  1  one-cycle pulse at the end of each sequence

Behaviour:
- Mode table, listed as H total/fp/bp/sync; V0 total/fp/bp/sync; V1 total/fp/bp/sync; hv_offset_0/1:
  - 0 = 640x480p60: H 800/16/48/96; V0=V1 525/10/33/2; hv_offset 0/0; progressive.
  - 1 = 720p60: H 1650/110/220/40; V 750/5/20/5; hv_offset 0/0; progressive.
  - 2 = 1080p60: H 2200/88/148/44; V 1125/4/36/5; hv_offset 0/0; progressive.
  - 3 = 1080i60: H 2200/88/148/44; V0 562/2/15/5; V1 563/2/16/5; hv_offset 0/1100; interlaced=1.
- Progressive modes drive V1 = V0.
- All outputs are registered.
- Reset values:
  - tg_reset=1; config=mode 0; pclk_sel=0; cur_mode=0.
  - busy=1; req_ready=0; mode_locked=0; mode_err=0; done=0.
  - Synchroniser and edge registers cleared.
  - FSM enters HOLD with target mode 0, which is the boot sequence.
- vs_rise = synced tg_vs 0->1, detected from the sync-stage and previous-stage registers.
- States:
  - IDLE: busy=0, req_ready=1. On accept: capture req_mode, clear mode_err.
    - If req_mode==cur_mode and mode_locked: done pulses next cycle; no reconfiguration; stay IDLE.
    - Else if mode_locked: go to WAIT_FRAME.
    - Else: go to HOLD.
  - WAIT_FRAME: on vs_rise or timeout, go to HOLD. The generator keeps running untouched.
  - HOLD: on entry cycle, tg_reset=1, mode_locked=0, config and pclk_sel loaded from the target, cur_mode=target. Stay RST_CYCLES cycles, then go to WAIT_PLL.
  - WAIT_PLL: count consecutive synced pll_locked=1 cycles; any 0 restarts the count. At PLL_STABLE, deassert tg_reset and go to WAIT_VS. There is no timeout here.
  - WAIT_VS: clear the timeout counter on entry.
    - vs_rise: mode_locked=1, done pulse, go to IDLE.
    - Timeout at TIMEOUT_CYCLES: mode_err=1, mode_locked=0, done pulse, go to IDLE. tg_reset stays 0.
- Config and pclk_sel change only on the HOLD entry cycle, so they are always stable while tg_reset=0.
- req_ready=0 outside IDLE. Requests presented while busy are not captured and must be held by the requester.
- The timeout counter saturates and is cleared on every state entry.
- Reset asserted mid-sequence restarts the boot sequence to mode 0 from any state.

Test Plan:
1. Boot: release reset with pll_locked=1 and a vsync model running.
   - Expect tg_reset=1 for RST_CYCLES+PLL_STABLE cycles, plus up to 2 cycles of sync latency.
   - Then on first vs_rise: mode_locked=1, cur_mode=0, h_total=800, v_total_0=525, done for exactly 1 cycle.
2. While locked, request mode 3.
   - tg_reset rises only after the next vs_rise.
   - Then interlaced=1, v_total_0=562, v_total_1=563, hv_offset_1=1100, pclk_sel=3; lock on the following vsync.
3. Request the current mode while locked.
   - Accepted, done pulses, tg_reset never asserts, busy stays 0.
4. pll_locked toggles low every 10 cycles during WAIT_PLL.
   - tg_reset stays 1.
   - Once pll_locked is held high, tg_reset deasserts exactly PLL_STABLE synced cycles later.
5. TIMEOUT_CYCLES=100, tg_vs held 0 after HOLD.
   - mode_err=1, mode_locked=0, done pulse 100 cycles into WAIT_VS.
   - The next accepted request clears mode_err.
6. Assert reset during WAIT_FRAME of a change to mode 2.
   - Config returns to mode 0, tg_reset=1, req_ready=0.
   - Boot sequence repeats as in scenario 1.
